// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: access-size encodings seen by
// the byte-lane RAM wrapper, sequencer state encoding, requester id width and
// a small id-to-one-hot helper.
package dmem_arbiter_pkg;

  localparam int ID_W = 1;

  // Access-size encodings understood by the RAM wrapper
  localparam logic [3:0] TYPE_BYTE     = 4'd0;
  localparam logic [3:0] TYPE_HALFWORD = 4'd1;
  localparam logic [3:0] TYPE_FULLWORD = 4'd2;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_RESP   = 2'd2
  } dmem_state_e;

  function automatic logic [1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot = (id == 1'b1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way arbiter with a combinational grant and a registered
// "last served" pointer. PRIO_MODE=0 alternates on contention, PRIO_MODE=1
// always favours port 0. One requester can be masked out for a cycle.
//   clk, rst_n   : clock, async active-low reset
//   req_i[1:0]   : raw requests
//   excl_en_i/excl_id_i : drop this requester from the contest
//   take_i       : the current grant is consumed; update the pointer
//   gnt_valid_o/gnt_id_o : winner (combinational)
module rr_arbiter2
  import dmem_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_i,
  input  logic            excl_en_i,
  input  logic [ID_W-1:0] excl_id_i,
  input  logic            take_i,
  output logic            gnt_valid_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic [1:0]      req_s;
  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;

  // Mask the excluded requester, then pick the winner
  always_comb begin
    req_s    = req_i;
    gnt_id_o = 1'b0;
    if (excl_en_i) begin
      req_s = req_i & ~id_onehot(excl_id_i);
    end else begin
      req_s = req_i;
    end
    gnt_valid_o = |req_s;
    case (req_s)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      // On contention round-robin favours whoever was not served last
      2'b11:   gnt_id_o = (PRIO_MODE != 0) ? 1'b0 : ~last_q;
      default: gnt_id_o = 1'b0;
    endcase
  end

  // Pointer next-state: follows each consumed grant
  always_comb begin
    if (take_i) begin
      last_d = gnt_id_o;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset so that port 0 is preferred first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises two requesters (0 = load/store unit, 1 = DMA)
// onto one byte-lane BRAM wrapper with 1-cycle read latency. Request fields
// are latched and held on ram_* through ACCESS and RESP so the wrapper's
// combinational read formatting stays valid while data returns.
//   pK_req/we/type/sign/addr/wdat_i : requester K transaction
//   pK_gnt_o  : accepted pulse     pK_done_o : completion pulse
//   pK_err_o  : misaligned (with done)  pK_rdata_o : load data, held
//   ram_*_o / ram_data_i / ram_misaligned_i : RAM wrapper interface
//   busy_o    : transaction in flight
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int W         = 32,
  parameter int L         = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         p0_req_i,
  input  logic         p0_we_i,
  input  logic [L-1:0] p0_type_i,
  input  logic         p0_sign_i,
  input  logic [W-1:0] p0_addr_i,
  input  logic [W-1:0] p0_wdat_i,
  output logic         p0_gnt_o,
  output logic         p0_done_o,
  output logic         p0_err_o,
  output logic [W-1:0] p0_rdata_o,
  input  logic         p1_req_i,
  input  logic         p1_we_i,
  input  logic [L-1:0] p1_type_i,
  input  logic         p1_sign_i,
  input  logic [W-1:0] p1_addr_i,
  input  logic [W-1:0] p1_wdat_i,
  output logic         p1_gnt_o,
  output logic         p1_done_o,
  output logic         p1_err_o,
  output logic [W-1:0] p1_rdata_o,
  output logic         ram_we_o,
  output logic         ram_re_o,
  output logic [L-1:0] ram_type_o,
  output logic         ram_sign_o,
  output logic [W-1:0] ram_addr_o,
  output logic [W-1:0] ram_wdat_o,
  input  logic [W-1:0] ram_data_i,
  input  logic         ram_misaligned_i,
  output logic         busy_o
);

  dmem_state_e     state_q, state_d;
  logic            latch_s;
  logic            arb_valid_s;
  logic [ID_W-1:0] arb_id_s;
  logic [1:0]      arb_req_s;
  logic [ID_W-1:0] id_q;
  logic            we_q, sign_q, acc_err_q;
  logic [L-1:0]    type_q;
  logic [W-1:0]    addr_q, wdat_q;
  logic [1:0]      gnt_q, done_q, err_q;
  logic [W-1:0]    rdata_q [2];

  // Only IDLE and RESP may start a transaction
  always_comb begin
    if (state_q == DMEM_IDLE || state_q == DMEM_RESP) begin
      arb_req_s = {p1_req_i, p0_req_i};
    end else begin
      arb_req_s = 2'b00;
    end
  end

  // In RESP the just-granted requester's req is stale, so it is excluded
  rr_arbiter2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (arb_req_s),
    .excl_en_i   (state_q == DMEM_RESP),
    .excl_id_i   (id_q),
    .take_i      (latch_s),
    .gnt_valid_o (arb_valid_s),
    .gnt_id_o    (arb_id_s)
  );

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    latch_s = 1'b0;
    case (state_q)
      DMEM_IDLE, DMEM_RESP: begin
        if (arb_valid_s) begin
          state_d = DMEM_ACCESS;
          latch_s = 1'b1;
        end else begin
          state_d = DMEM_IDLE;
          latch_s = 1'b0;
        end
      end
      DMEM_ACCESS: state_d = DMEM_RESP;
      default:     state_d = DMEM_IDLE;
    endcase
  end

  // State, winner's latched fields, grant pulse and sampled misalignment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DMEM_IDLE;
      id_q      <= {ID_W{1'b0}};
      we_q      <= 1'b0;
      sign_q    <= 1'b0;
      type_q    <= {L{1'b0}};
      addr_q    <= {W{1'b0}};
      wdat_q    <= {W{1'b0}};
      gnt_q     <= 2'b00;
      acc_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= 2'b00;
      if (latch_s) begin
        id_q  <= arb_id_s;
        gnt_q <= id_onehot(arb_id_s);
        if (arb_id_s == 1'b1) begin
          we_q <= p1_we_i; sign_q <= p1_sign_i; type_q <= p1_type_i;
          addr_q <= p1_addr_i; wdat_q <= p1_wdat_i;
        end else begin
          we_q <= p0_we_i; sign_q <= p0_sign_i; type_q <= p0_type_i;
          addr_q <= p0_addr_i; wdat_q <= p0_wdat_i;
        end
      end
      if (state_q == DMEM_ACCESS) begin
        acc_err_q <= ram_misaligned_i;
      end
    end
  end

  // Completion: done/err pulses and read data captured at the end of RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= {W{1'b0}};
      rdata_q[1] <= {W{1'b0}};
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      if (state_q == DMEM_RESP) begin
        done_q <= id_onehot(id_q);
        err_q  <= acc_err_q ? id_onehot(id_q) : 2'b00;
        if (acc_err_q) begin
          rdata_q[id_q] <= {W{1'b0}};
        end else if (!we_q) begin
          rdata_q[id_q] <= ram_data_i;
        end
      end
    end
  end

  // RAM drive; write enable decodes from state so reset kills it at once
  always_comb begin
    ram_we_o   = 1'b0;
    ram_re_o   = 1'b0;
    ram_type_o = {L{1'b0}};
    ram_sign_o = 1'b0;
    ram_addr_o = {W{1'b0}};
    ram_wdat_o = {W{1'b0}};
    if (state_q == DMEM_ACCESS || state_q == DMEM_RESP) begin
      ram_re_o   = ~we_q;
      ram_type_o = type_q;
      ram_sign_o = sign_q;
      ram_addr_o = addr_q;
      ram_wdat_o = wdat_q;
      if (state_q == DMEM_ACCESS) begin
        ram_we_o = we_q & ~ram_misaligned_i;
      end else begin
        ram_we_o = 1'b0;
      end
    end else begin
      ram_we_o = 1'b0;
    end
  end

  assign p0_gnt_o   = gnt_q[0];
  assign p1_gnt_o   = gnt_q[1];
  assign p0_done_o  = done_q[0];
  assign p1_done_o  = done_q[1];
  assign p0_err_o   = err_q[0];
  assign p1_err_o   = err_q[1];
  assign p0_rdata_o = rdata_q[0];
  assign p1_rdata_o = rdata_q[1];
  assign busy_o     = (state_q != DMEM_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A (round-robin) talks to a behavioural
// byte-lane BRAM; instance B (fixed priority) only exercises grant order.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Requester side, indexed [dut][port]
  logic        req  [2][2];
  logic        we   [2][2];
  logic [3:0]  ty   [2][2];
  logic        sg   [2][2];
  logic [31:0] ad   [2][2];
  logic [31:0] wd   [2][2];
  logic        gnt  [2][2];
  logic        done [2][2];
  logic        err  [2][2];
  logic [31:0] rd   [2][2];
  logic        busy_a, busy_b;

  logic        a_ram_we, a_ram_re, a_ram_sign, a_ram_mis;
  logic [3:0]  a_ram_type;
  logic [31:0] a_ram_addr, a_ram_wdat, a_ram_data;
  logic        b_ram_we, b_ram_re, b_ram_sign;
  logic [3:0]  b_ram_type;
  logic [31:0] b_ram_addr, b_ram_wdat;

  dmem_arbiter #(.W(32), .L(4), .PRIO_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(req[0][0]), .p0_we_i(we[0][0]), .p0_type_i(ty[0][0]), .p0_sign_i(sg[0][0]),
    .p0_addr_i(ad[0][0]), .p0_wdat_i(wd[0][0]), .p0_gnt_o(gnt[0][0]), .p0_done_o(done[0][0]),
    .p0_err_o(err[0][0]), .p0_rdata_o(rd[0][0]),
    .p1_req_i(req[0][1]), .p1_we_i(we[0][1]), .p1_type_i(ty[0][1]), .p1_sign_i(sg[0][1]),
    .p1_addr_i(ad[0][1]), .p1_wdat_i(wd[0][1]), .p1_gnt_o(gnt[0][1]), .p1_done_o(done[0][1]),
    .p1_err_o(err[0][1]), .p1_rdata_o(rd[0][1]),
    .ram_we_o(a_ram_we), .ram_re_o(a_ram_re), .ram_type_o(a_ram_type), .ram_sign_o(a_ram_sign),
    .ram_addr_o(a_ram_addr), .ram_wdat_o(a_ram_wdat), .ram_data_i(a_ram_data),
    .ram_misaligned_i(a_ram_mis), .busy_o(busy_a)
  );

  dmem_arbiter #(.W(32), .L(4), .PRIO_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(req[1][0]), .p0_we_i(we[1][0]), .p0_type_i(ty[1][0]), .p0_sign_i(sg[1][0]),
    .p0_addr_i(ad[1][0]), .p0_wdat_i(wd[1][0]), .p0_gnt_o(gnt[1][0]), .p0_done_o(done[1][0]),
    .p0_err_o(err[1][0]), .p0_rdata_o(rd[1][0]),
    .p1_req_i(req[1][1]), .p1_we_i(we[1][1]), .p1_type_i(ty[1][1]), .p1_sign_i(sg[1][1]),
    .p1_addr_i(ad[1][1]), .p1_wdat_i(wd[1][1]), .p1_gnt_o(gnt[1][1]), .p1_done_o(done[1][1]),
    .p1_err_o(err[1][1]), .p1_rdata_o(rd[1][1]),
    .ram_we_o(b_ram_we), .ram_re_o(b_ram_re), .ram_type_o(b_ram_type), .ram_sign_o(b_ram_sign),
    .ram_addr_o(b_ram_addr), .ram_wdat_o(b_ram_wdat), .ram_data_i(32'h0000_0000),
    .ram_misaligned_i(1'b0), .busy_o(busy_b)
  );

  // Behavioural byte-lane BRAM for instance A
  logic [31:0] mem [64];
  logic [31:0] rd_word_q;
  logic [31:0] sh;

  always @(posedge clk) begin
    if (a_ram_we) begin
      case (a_ram_type)
        TYPE_BYTE:     mem[a_ram_addr[7:2]][{a_ram_addr[1:0], 3'b000} +: 8] <= a_ram_wdat[7:0];
        TYPE_HALFWORD: mem[a_ram_addr[7:2]][{a_ram_addr[1], 4'b0000} +: 16] <= a_ram_wdat[15:0];
        default:       mem[a_ram_addr[7:2]] <= a_ram_wdat;
      endcase
    end
    if (a_ram_re) rd_word_q <= mem[a_ram_addr[7:2]];
  end

  always_comb begin
    sh = rd_word_q >> {a_ram_addr[1:0], 3'b000};
    a_ram_mis = ((a_ram_type == TYPE_HALFWORD) && a_ram_addr[0]) ||
                ((a_ram_type == TYPE_FULLWORD) && (a_ram_addr[1:0] != 2'b00));
    case (a_ram_type)
      TYPE_BYTE:     a_ram_data = a_ram_sign ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
      TYPE_HALFWORD: a_ram_data = a_ram_sign ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      default:       a_ram_data = rd_word_q;
    endcase
  end

  int we_cnt = 0;
  always @(negedge clk) if (a_ram_we) we_cnt <= we_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues: responses per dut*2+port, grant order per dut
  exp_t expq [4][$];
  int   gq   [2][$];
  int   gnt_cyc [2][2];
  int   tp_prev [2];
  logic tp_en   [2];

  // Monitor: grant order, gnt->done latency, responses, throughput
  always @(negedge clk) begin
    exp_t e;
    int   eid;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (gnt[d][p]) begin
          gnt_cyc[d][p] = cyc;
          if (gq[d].size() == 0) begin
            check($sformatf("gnt_unexpected_d%0d_p%0d", d, p), 32'd1, 32'd0);
          end else begin
            eid = gq[d].pop_front();
            check($sformatf("gnt_order_d%0d", d), p, eid);
          end
        end
        if (done[d][p]) begin
          check($sformatf("done_latency_d%0d_p%0d", d, p), cyc - gnt_cyc[d][p], 32'd2);
          if (expq[d*2+p].size() == 0) begin
            check($sformatf("done_unexpected_d%0d_p%0d", d, p), 32'd1, 32'd0);
          end else begin
            e = expq[d*2+p].pop_front();
            check($sformatf("err_d%0d_p%0d", d, p), {31'd0, err[d][p]}, {31'd0, e.err});
            if (e.chk_rd) check($sformatf("rdata_d%0d_p%0d", d, p), rd[d][p], e.rdata);
          end
          if (tp_en[d]) begin
            if (tp_prev[d] >= 0) check($sformatf("throughput_d%0d", d), cyc - tp_prev[d], 32'd2);
            tp_prev[d] = cyc;
          end
        end
      end
    end
  end

  task automatic issue(input int d, input int p, input logic w, input logic [3:0] t,
                       input logic s, input logic [31:0] a, input logic [31:0] wdat,
                       input logic chk, input logic [31:0] erd, input logic eer, input logic pg);
    exp_t e;
    int   n;
    e.chk_rd = chk; e.rdata = erd; e.err = eer;
    expq[d*2+p].push_back(e);
    if (pg) gq[d].push_back(p);
    we[d][p] = w; ty[d][p] = t; sg[d][p] = s; ad[d][p] = a; wd[d][p] = wdat;
    req[d][p] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[d][p] && n < 100);
    if (!gnt[d][p]) check($sformatf("gnt_timeout_d%0d_p%0d", d, p), 32'd0, 32'd1);
    @(posedge clk);
    #1 req[d][p] = 1'b0;
  endtask

  task automatic ld(input int d, input int p, input logic [3:0] t, input logic s,
                    input logic [31:0] a, input logic [31:0] erd, input logic eer, input logic pg);
    issue(d, p, 1'b0, t, s, a, 32'h0000_0000, 1'b1, erd, eer, pg);
  endtask

  task automatic st(input int d, input int p, input logic [3:0] t, input logic [31:0] a,
                    input logic [31:0] wdat, input logic eer);
    // A misaligned store returns rdata 0; a good store leaves rdata alone
    issue(d, p, 1'b1, t, 1'b0, a, wdat, eer, 32'h0000_0000, eer, 1'b1);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int we0;
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tp_en[d] = 1'b0; tp_prev[d] = -1;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; ty[d][p] = 4'd0; sg[d][p] = 1'b0;
        ad[d][p] = 32'h0; wd[d][p] = 32'h0; gnt_cyc[d][p] = 0;
      end
    end
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ram_we", {31'd0, a_ram_we}, 32'd0);
    check("rst_ram_addr", a_ram_addr, 32'd0);
    check("rst_gnt", {31'd0, gnt[0][0]}, 32'd0);
    check("rst_rdata", rd[0][1], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned store then load of the same word
    we0 = we_cnt;
    st(0, 0, TYPE_FULLWORD, 32'h10, 32'hDEADBEEF, 1'b0);
    settle();
    check("store_we_cycles", we_cnt - we0, 32'd1);
    ld(0, 0, TYPE_FULLWORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
    settle();

    // Sub-word loads with and without sign extension
    st(0, 0, TYPE_FULLWORD, 32'h10, 32'h80FF7F01, 1'b0);
    ld(0, 1, TYPE_BYTE, 1'b1, 32'h13, 32'hFFFFFF80, 1'b0, 1'b1);
    ld(0, 1, TYPE_BYTE, 1'b0, 32'h13, 32'h00000080, 1'b0, 1'b1);
    ld(0, 1, TYPE_HALFWORD, 1'b1, 32'h12, 32'hFFFF80FF, 1'b0, 1'b1);
    ld(0, 1, TYPE_BYTE, 1'b1, 32'h11, 32'h0000007F, 1'b0, 1'b1);
    settle();

    // Misaligned store is suppressed; misaligned load returns 0 with err
    we0 = we_cnt;
    st(0, 0, TYPE_HALFWORD, 32'h11, 32'h00001234, 1'b1);
    settle();
    check("misaligned_no_we", we_cnt - we0, 32'd0);
    ld(0, 0, TYPE_FULLWORD, 1'b0, 32'h10, 32'h80FF7F01, 1'b0, 1'b1);
    ld(0, 1, TYPE_FULLWORD, 1'b0, 32'h12, 32'h00000000, 1'b1, 1'b1);
    st(0, 0, TYPE_FULLWORD, 32'h20, 32'h11111111, 1'b0);
    settle();
    check("store_holds_rdata", rd[0][0], 32'h80FF7F01);

    // Reset during ACCESS of a store: write aborted, no done
    gq[0].push_back(0);
    we[0][0] = 1'b1; ty[0][0] = TYPE_FULLWORD; ad[0][0] = 32'h20; wd[0][0] = 32'h22222222;
    req[0][0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[0][0] && n < 100);
    check("abort_gnt_seen", {31'd0, gnt[0][0]}, 32'd1);
    check("abort_we_in_access", {31'd0, a_ram_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we_async", {31'd0, a_ram_we}, 32'd0);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    req[0][0] = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_mem_unchanged", mem[8], 32'h11111111);
    check("abort_rdata_cleared", rd[0][0], 32'd0);
    rst_n = 1'b1;
    settle();

    // Both requesting after reset: port 0 first, then strict alternation
    for (int i = 0; i < 4; i++) begin
      gq[0].push_back(0);
      gq[0].push_back(1);
    end
    tp_prev[0] = -1; tp_en[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) ld(0, 0, TYPE_FULLWORD, 1'b0, 32'h20, 32'h11111111, 1'b0, 1'b0);
      end
      begin
        for (int j = 0; j < 4; j++) ld(0, 1, TYPE_BYTE, 1'b0, 32'h10, 32'h00000001, 1'b0, 1'b0);
      end
    join
    settle();
    tp_en[0] = 1'b0;

    // Round-robin: after serving port 0, contention goes to port 1
    ld(0, 0, TYPE_FULLWORD, 1'b0, 32'h20, 32'h11111111, 1'b0, 1'b1);
    settle();
    gq[0].push_back(1);
    gq[0].push_back(0);
    fork
      ld(0, 0, TYPE_FULLWORD, 1'b0, 32'h10, 32'h80FF7F01, 1'b0, 1'b0);
      ld(0, 1, TYPE_FULLWORD, 1'b0, 32'h20, 32'h11111111, 1'b0, 1'b0);
    join
    settle();

    // Fixed priority: after serving port 0, contention still goes to port 0
    ld(1, 0, TYPE_FULLWORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle();
    for (int i = 0; i < 3; i++) begin
      gq[1].push_back(0);
      gq[1].push_back(1);
    end
    tp_prev[1] = -1; tp_en[1] = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) ld(1, 0, TYPE_FULLWORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      end
      begin
        for (int j = 0; j < 3; j++) ld(1, 1, TYPE_FULLWORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      end
    join
    settle();
    tp_en[1] = 1'b0;

    for (int k = 0; k < 4; k++) check($sformatf("resp_left_%0d", k), expq[k].size(), 32'd0);
    for (int k = 0; k < 2; k++) check($sformatf("gnt_left_%0d", k), gq[k].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
